// File: rtl/encrypt_stream.sv
// LWE (Regev-style) encryptor: sums the public-key rows picked by r, adds the
// scaled plaintext to the last column, and streams out the n+1 ciphertext entries.
module encrypt_stream #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 10,
  parameter int BIG_N              = 30
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
  input  logic [BIG_N-1:0]            rand_bits,
  input  logic [CIPHERTEXT_WIDTH-1:0] pk_entry,
  input  logic                        pk_valid,
  output logic                        pk_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] ct_data,
  output logic                        ct_valid,
  input  logic                        ct_ready,
  output logic                        ct_last,
  output logic                        busy,
  output logic                        done
);
  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int ROW_W = (BIG_N > 1) ? $clog2(BIG_N) : 1;
  localparam int COL_W = $clog2(DIMENSION + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BIG_N - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DIMENSION);
  localparam logic [CW-1:0]    DELTA    = CW'(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);
  localparam logic [CW-1:0]    Q_MASK   = CW'(CIPHERTEXT_MODULUS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  logic [1:0]                 r_state;
  logic [PLAINTEXT_WIDTH-1:0] r_plaintext;
  logic [BIG_N-1:0]           r_rand;
  logic [CW-1:0]              r_acc [0:DIMENSION];
  logic [ROW_W-1:0]           r_row;
  logic [COL_W-1:0]           r_col;
  logic [COL_W-1:0]           r_idx;
  logic [CW-1:0]              r_ct_data;
  logic                       r_ct_valid;
  logic                       r_ct_last;
  logic                       r_done;

  logic [CW-1:0]    w_encoded;
  logic [CW-1:0]    w_sum;
  logic [COL_W-1:0] w_idx_next;
  logic             w_col_last;
  logic             w_row_last;

  assign w_encoded  = CW'(r_plaintext) * DELTA;
  assign w_sum      = (r_acc[r_col] + pk_entry) & Q_MASK;
  assign w_idx_next = r_idx + COL_W'(1);
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  assign pk_ready = (r_state == ST_LOAD);
  assign busy     = (r_state != ST_IDLE);
  assign ct_data  = r_ct_data;
  assign ct_valid = r_ct_valid;
  assign ct_last  = r_ct_last;
  assign done     = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_plaintext <= '0;
      r_rand      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_idx       <= '0;
      r_ct_data   <= '0;
      r_ct_valid  <= 1'b0;
      r_ct_last   <= 1'b0;
      r_done      <= 1'b0;
      for (int k = 0; k <= DIMENSION; k++) r_acc[k] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_plaintext <= plaintext;
            r_rand      <= rand_bits;
            r_row       <= '0;
            r_col       <= '0;
            r_state     <= ST_LOAD;
            for (int k = 0; k <= DIMENSION; k++) r_acc[k] <= '0;
          end
        end
        ST_LOAD: begin
          // The encoded message seeds the c2 column while the counters sit at
          // (0,0); column DIMENSION is not touched again until row 0 reaches it.
          if (r_row == '0 && r_col == '0) r_acc[DIMENSION] <= w_encoded;
          if (pk_valid) begin
            if (r_rand[r_row]) r_acc[r_col] <= w_sum;
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                r_state    <= ST_EMIT;
                r_idx      <= '0;
                r_ct_valid <= 1'b1;
                r_ct_data  <= r_acc[0];
                r_ct_last  <= (DIMENSION == 0);
              end else begin
                r_row <= r_row + ROW_W'(1);
              end
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (ct_ready) begin
            if (r_ct_last) begin
              r_state    <= ST_IDLE;
              r_ct_valid <= 1'b0;
              r_ct_last  <= 1'b0;
              r_idx      <= '0;
              r_done     <= 1'b1;
            end else begin
              r_idx     <= w_idx_next;
              r_ct_data <= r_acc[w_idx_next];
              r_ct_last <= (w_idx_next == COL_LAST);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_encrypt_stream.sv
// Directed-vector bench for encrypt_stream: hand-computed ciphertexts for
// several keys/selections, with stall, backpressure and reset-abort scenarios.
module tb_encrypt_stream;
  localparam int PW = 6;
  localparam int CW = 10;
  localparam int D  = 10;
  localparam int M  = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] plaintext = '0;
  logic [M-1:0]  rand_bits = '0;
  logic [CW-1:0] pk_entry = '0;
  logic          pk_valid = 1'b0;
  logic          ct_ready = 1'b0;
  logic          pk_ready;
  logic [CW-1:0] ct_data;
  logic          ct_valid;
  logic          ct_last;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;
  logic [CW-1:0] exp_ct [0:D];

  encrypt_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .plaintext(plaintext),
    .rand_bits(rand_bits), .pk_entry(pk_entry), .pk_valid(pk_valid),
    .pk_ready(pk_ready), .ct_data(ct_data), .ct_valid(ct_valid),
    .ct_ready(ct_ready), .ct_last(ct_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [CW-1:0] pk_val(input int mode, input int r, input int c);
    case (mode)
      0:       return CW'((r * 7 + c * 3) % 1024);
      1:       return CW'(1);
      2:       return CW'(1023);
      default: return CW'(r + c);
    endcase
  endfunction

  task automatic do_start(input logic [PW-1:0] pt, input logic [M-1:0] rb);
    plaintext = pt;
    rand_bits = rb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_pk_ready", pk_ready, 1);
    chk("start_ct_valid", ct_valid, 0);
  endtask

  // Presents `limit` entries in row-major order; with gap=1 every handshake is
  // followed by an idle cycle carrying a junk value that must not be counted.
  task automatic feed_pk(input int mode, input bit gap, input int limit);
    for (int k = 0; k < limit; k++) begin
      pk_entry = pk_val(mode, k / (D + 1), k % (D + 1));
      pk_valid = 1'b1;
      @(posedge clk); #1;
      if (gap && k != limit - 1) begin
        pk_valid = 1'b0;
        pk_entry = CW'(777);
        #1;
        chk("pk_ready_gap", pk_ready, 1);
        @(posedge clk); #1;
        chk("pk_ready_after_gap", pk_ready, 1);
      end
    end
    pk_valid = 1'b0;
  endtask

  task automatic collect_ct(input int stall_idx, input bit pulse_start);
    ct_ready = 1'b1;
    for (int idx = 0; idx <= D; idx++) begin
      int w = 0;
      while (ct_valid !== 1'b1 && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      chk($sformatf("ct_valid[%0d]", idx), ct_valid, 1);
      chk($sformatf("ct_data[%0d]", idx), ct_data, exp_ct[idx]);
      chk($sformatf("ct_last[%0d]", idx), ct_last, (idx == D) ? 1 : 0);
      if (idx == stall_idx) begin
        ct_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          if (pulse_start && s == 1) begin
            start = 1'b1;
            plaintext = 6'd60;
            rand_bits = '0;
          end
          @(posedge clk); #1;
          start = 1'b0;
          chk($sformatf("stall_data[%0d]", s), ct_data, exp_ct[idx]);
          chk($sformatf("stall_valid[%0d]", s), ct_valid, 1);
          chk($sformatf("stall_busy[%0d]", s), busy, 1);
        end
        ct_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    ct_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_ct_valid", ct_valid, 0);
    @(posedge clk); #1;
    chk("done_once", done, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pk_ready"}, pk_ready, 0);
    chk({tag, "_ct_valid"}, ct_valid, 0);
    chk({tag, "_ct_last"}, ct_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ct_data"}, ct_data, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero selection: ct[0..9]=0, ct[10]=5*16=80
    for (int j = 0; j < D; j++) exp_ct[j] = CW'(0);
    exp_ct[D] = CW'(80);
    do_start(6'd5, '0);
    feed_pk(0, 1'b0, M * (D + 1));
    collect_ct(-1, 1'b0);

    // All rows, unit key: 30 per column, c2 = 30 + 3*16 = 78
    for (int j = 0; j < D; j++) exp_ct[j] = CW'(30);
    exp_ct[D] = CW'(78);
    do_start(6'd3, '1);
    feed_pk(1, 1'b0, M * (D + 1));
    collect_ct(-1, 1'b0);

    // Wrap-around: 30*1023 mod 1024 = 994, c2 = (994 + 63*16) mod 1024 = 978
    for (int j = 0; j < D; j++) exp_ct[j] = CW'(994);
    exp_ct[D] = CW'(978);
    do_start(6'd63, '1);
    feed_pk(2, 1'b0, M * (D + 1));
    collect_ct(-1, 1'b0);

    // Rows 0 and 29 with entry=row+col and pk_valid gaps: 29+2j, plaintext 0
    for (int j = 0; j <= D; j++) exp_ct[j] = CW'(29 + 2 * j);
    do_start(6'd0, 30'h2000_0001);
    feed_pk(3, 1'b1, M * (D + 1));
    collect_ct(-1, 1'b0);

    // Backpressure at idx 4 plus an ignored start pulse during EMIT
    for (int j = 0; j < D; j++) exp_ct[j] = CW'(30);
    exp_ct[D] = CW'(78);
    do_start(6'd3, '1);
    feed_pk(1, 1'b0, M * (D + 1));
    collect_ct(4, 1'b1);
    chk("post_stall_idle", busy, 0);

    // Reset after 100 handshakes, then a clean run must show no residue
    do_start(6'd7, '1);
    feed_pk(2, 1'b0, 100);
    chk("mid_load_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < D; j++) exp_ct[j] = CW'(0);
    exp_ct[D] = CW'(80);
    do_start(6'd5, '0);
    feed_pk(0, 1'b0, M * (D + 1));
    collect_ct(-1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/encrypt_stream.md
# encrypt_stream

LWE (Regev-style) encryptor that pairs with the team's decrypt datapath. On `start`, it latches a plaintext and a random row-selection vector `r`. It then streams the public key (BIG_N rows of DIMENSION+1 entries each) through a valid/ready input and accumulates the selected rows modulo CIPHERTEXT_MODULUS. Finally it emits the DIMENSION+1 ciphertext entries over a valid/ready output, in the order the decrypt side consumes them.

## Interface
- PLAINTEXT_MODULUS, 64, message modulus p; must be a power of two.
- PLAINTEXT_WIDTH, 6, log2(p).
- CIPHERTEXT_MODULUS, 1024, ciphertext modulus q; must be a power of two, q > p.
- CIPHERTEXT_WIDTH, 10, log2(q).
- DIMENSION, 10, LWE dimension n; each ciphertext has n+1 entries.
- BIG_N, 30, number of public-key rows m.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin an encryption; sampled only in IDLE.
- plaintext  in  PLAINTEXT_WIDTH  message; latched with start.
- rand_bits  in  BIG_N  selection vector r (bit i selects row i); latched with start.
- pk_entry  in  CIPHERTEXT_WIDTH  public-key entry, row-major: a_i[0..n-1], then b_i.
- pk_valid  in  1  pk_entry valid.
- pk_ready  out  1  block accepts pk_entry.
- ct_data  out  CIPHERTEXT_WIDTH  ciphertext entry.
- ct_valid  out  1  ct_data valid.
- ct_ready  in  1  downstream accepts ct_data.
- ct_last  out  1  high with the final entry (index DIMENSION, c2).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last ct handshake.

## Operation
- State machine: IDLE -> LOAD -> EMIT -> IDLE.
- IDLE + start:
  - latch plaintext and rand_bits;
  - clear acc[0..DIMENSION-1] to 0;
  - set acc[DIMENSION] = plaintext * DELTA, where DELTA = q/p (a left shift by CIPHERTEXT_WIDTH-PLAINTEXT_WIDTH);
  - zero row/col counters; go to LOAD.
- LOAD: pk_ready=1. On each pk handshake at (row, col):
  - if r[row]=1, acc[col] <= (acc[col] + pk_entry) mod q; otherwise acc[col] is unchanged;
  - col increments 0..DIMENSION, then wraps to 0 and row increments;
  - on the handshake at row=BIG_N-1, col=DIMENSION, go to EMIT.
- EMIT: ct_valid=1 and ct_data=acc[idx], with idx running 0..DIMENSION.
  - idx advances only on a ct handshake.
  - ct_last=1 when idx=DIMENSION.
  - The handshake on the last entry returns the block to IDLE and pulses done.
- Arithmetic: all sums truncate to CIPHERTEXT_WIDTH bits (mod q is implicit because q is a power of two). No sign handling; entries are unsigned residues.
- start while busy: ignored; latched values are not disturbed.
- pk_valid outside LOAD: ignored; pk_ready=0.
- ct_ready while ct_valid=0: no effect.

## Timing
- Reset values: state IDLE; pk_ready=0, ct_valid=0, ct_last=0, busy=0, done=0, ct_data=0; all acc, counters, latched r and plaintext = 0.
- Reset has priority over every other event, including mid-LOAD and mid-EMIT. The block is in IDLE the cycle after rst_n is sampled low; a partial ciphertext is never emitted.
- The start handshake at edge T puts the block in LOAD from cycle T+1, with pk_ready=1.
- One pk entry per cycle at most. Full-rate LOAD takes BIG_N*(DIMENSION+1) cycles (330 at defaults).
- The last pk handshake at edge T gives ct_valid=1 from cycle T+1.
- ct_data, ct_valid and ct_last are registered and held stable while ct_valid=1 and ct_ready=0.
- One ct entry per cycle at most. Minimum start-to-done is 1 + 330 + 11 cycles at defaults.
- done is asserted in the cycle after the final ct handshake, together with busy=0. start is accepted in that same cycle.
- pk_ready is a function of state only; it is not combinationally dependent on pk_valid.

## Test plan
- Zero selection: plaintext=5, rand_bits=0, arbitrary pk -> ct[0..9]=0, ct[10]=80, ct_last only on entry 10, done pulses once.
- All selected, unit key: rand_bits all ones, every pk_entry=1, plaintext=3 -> ct[0..9]=30, ct[10]=30+48=78.
- Wrap-around: rand_bits all ones, every pk_entry=1023, plaintext=63 -> ct[0..9]=994, ct[10]=(994+1008) mod 1024=978.
- Sparse selection and stall: rand_bits=bit0|bit29, pk_entry=row index+col, pk_valid toggling every other cycle -> ct[j]=(0+j)+(29+j)=29+2j. Expect pk_ready steady across the toggling and no entry double-counted.
- Backpressure and start-while-busy: hold ct_ready=0 for 5 cycles at idx 4 and pulse start during EMIT -> ct_data stays at entry 4 throughout, the start pulse is ignored, and the sequence completes unchanged.
- Reset mid-LOAD: assert rst_n=0 after 100 pk handshakes -> next cycle the block is in IDLE with all outputs 0. A fresh encryption (plaintext=5, rand_bits=0) then yields ct[10]=80 with no residue from the aborted run.
